fpga: RTL and testbench

Shared serial-bus transmitter for 16 local stations. Each station presents a frame (receiver address, mode, 64-bit data, 4-bit CRC). The block arbitrates among requesting stations, then serializes the granted station's frame onto the single-bit output `bus_out`, one bit per clock. It is the top-level bus front end of the design.

---
 rtl/fpga.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fpga.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga.sv
// fpga: 16-station round-robin serial bus transmitter, 79-bit frames followed by GAP_CYCLES idle cycles.
// Optional macro CRC_GEN_EN: replace the station CRC field with an internally generated CRC-4 (x^4+x+1).
module fpga #(
   parameter int GAP_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  CRC1,
   input  logic [3:0]  CRC2,
   input  logic [3:0]  CRC3,
   input  logic [3:0]  CRC4,
   input  logic [3:0]  CRC5,
   input  logic [3:0]  CRC6,
   input  logic [3:0]  CRC7,
   input  logic [3:0]  CRC8,
   input  logic [3:0]  CRC9,
   input  logic [3:0]  CRC10,
   input  logic [3:0]  CRC11,
   input  logic [3:0]  CRC12,
   input  logic [3:0]  CRC13,
   input  logic [3:0]  CRC14,
   input  logic [3:0]  CRC15,
   input  logic [3:0]  CRC16,
   input  logic [63:0] Data1,
   input  logic [63:0] Data2,
   input  logic [63:0] Data3,
   input  logic [63:0] Data4,
   input  logic [63:0] Data5,
   input  logic [63:0] Data6,
   input  logic [63:0] Data7,
   input  logic [63:0] Data8,
   input  logic [63:0] Data9,
   input  logic [63:0] Data10,
   input  logic [63:0] Data11,
   input  logic [63:0] Data12,
   input  logic [63:0] Data13,
   input  logic [63:0] Data14,
   input  logic [63:0] Data15,
   input  logic [63:0] Data16,
   input  logic [3:0]  receiverAddr1,
   input  logic [3:0]  receiverAddr2,
   input  logic [3:0]  receiverAddr3,
   input  logic [3:0]  receiverAddr4,
   input  logic [3:0]  receiverAddr5,
   input  logic [3:0]  receiverAddr6,
   input  logic [3:0]  receiverAddr7,
   input  logic [3:0]  receiverAddr8,
   input  logic [3:0]  receiverAddr9,
   input  logic [3:0]  receiverAddr10,
   input  logic [3:0]  receiverAddr11,
   input  logic [3:0]  receiverAddr12,
   input  logic [3:0]  receiverAddr13,
   input  logic [3:0]  receiverAddr14,
   input  logic [3:0]  receiverAddr15,
   input  logic [3:0]  receiverAddr16,
   input  logic [1:0]  mod1,
   input  logic [1:0]  mod2,
   input  logic [1:0]  mod3,
   input  logic [1:0]  mod4,
   input  logic [1:0]  mod5,
   input  logic [1:0]  mod6,
   input  logic [1:0]  mod7,
   input  logic [1:0]  mod8,
   input  logic [1:0]  mod9,
   input  logic [1:0]  mod10,
   input  logic [1:0]  mod11,
   input  logic [1:0]  mod12,
   input  logic [1:0]  mod13,
   input  logic [1:0]  mod14,
   input  logic [1:0]  mod15,
   input  logic [1:0]  mod16,
   output logic        bus_out
);

   localparam int DATA_W  = 64;
   localparam int SHIFT_W = 78;   // frame bits 1..78; the start bit is driven directly

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t             state_q, state_d;
   logic [1:0]         mod_a  [16];
   logic [3:0]         addr_a [16];
   logic [DATA_W-1:0]  data_a [16];
   logic [3:0]         ptr_q;          // round-robin pointer, holds p-1
   logic [6:0]         bit_cnt_q;
   logic [3:0]         gap_cnt_q;
   logic [SHIFT_W-1:0] shift_q;
   logic [SHIFT_W-1:0] frame_tail;
   logic [3:0]         sel_addr;
   logic [3:0]         sel_crc;
   logic [3:0]         idx;
   logic [3:0]         win_hi, win_lo, win;
   logic               found_hi, found_lo, any_req;

   assign mod_a[0]  = mod1;
   assign mod_a[1]  = mod2;
   assign mod_a[2]  = mod3;
   assign mod_a[3]  = mod4;
   assign mod_a[4]  = mod5;
   assign mod_a[5]  = mod6;
   assign mod_a[6]  = mod7;
   assign mod_a[7]  = mod8;
   assign mod_a[8]  = mod9;
   assign mod_a[9]  = mod10;
   assign mod_a[10] = mod11;
   assign mod_a[11] = mod12;
   assign mod_a[12] = mod13;
   assign mod_a[13] = mod14;
   assign mod_a[14] = mod15;
   assign mod_a[15] = mod16;

   assign addr_a[0]  = receiverAddr1;
   assign addr_a[1]  = receiverAddr2;
   assign addr_a[2]  = receiverAddr3;
   assign addr_a[3]  = receiverAddr4;
   assign addr_a[4]  = receiverAddr5;
   assign addr_a[5]  = receiverAddr6;
   assign addr_a[6]  = receiverAddr7;
   assign addr_a[7]  = receiverAddr8;
   assign addr_a[8]  = receiverAddr9;
   assign addr_a[9]  = receiverAddr10;
   assign addr_a[10] = receiverAddr11;
   assign addr_a[11] = receiverAddr12;
   assign addr_a[12] = receiverAddr13;
   assign addr_a[13] = receiverAddr14;
   assign addr_a[14] = receiverAddr15;
   assign addr_a[15] = receiverAddr16;

   assign data_a[0]  = Data1;
   assign data_a[1]  = Data2;
   assign data_a[2]  = Data3;
   assign data_a[3]  = Data4;
   assign data_a[4]  = Data5;
   assign data_a[5]  = Data6;
   assign data_a[6]  = Data7;
   assign data_a[7]  = Data8;
   assign data_a[8]  = Data9;
   assign data_a[9]  = Data10;
   assign data_a[10] = Data11;
   assign data_a[11] = Data12;
   assign data_a[12] = Data13;
   assign data_a[13] = Data14;
   assign data_a[14] = Data15;
   assign data_a[15] = Data16;

`ifdef CRC_GEN_EN
   logic [63:0] crc_in_unused;
   logic [3:0]  crc_q;

   assign crc_in_unused = {CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                           CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
   assign sel_crc = 4'h0;

   function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
      logic fb;
      fb = c[3] ^ b;
      return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
   endfunction
`else
   logic [3:0] crc_a [16];

   assign crc_a[0]  = CRC1;
   assign crc_a[1]  = CRC2;
   assign crc_a[2]  = CRC3;
   assign crc_a[3]  = CRC4;
   assign crc_a[4]  = CRC5;
   assign crc_a[5]  = CRC6;
   assign crc_a[6]  = CRC7;
   assign crc_a[7]  = CRC8;
   assign crc_a[8]  = CRC9;
   assign crc_a[9]  = CRC10;
   assign crc_a[10] = CRC11;
   assign crc_a[11] = CRC12;
   assign crc_a[12] = CRC13;
   assign crc_a[13] = CRC14;
   assign crc_a[14] = CRC15;
   assign crc_a[15] = CRC16;
   assign sel_crc   = crc_a[win];
`endif

   // Arbitration: first high-priority requester from the pointer upward, else first requester
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      idx      = '0;
      for (int off = 0; off < 16; off++) begin
         idx = ptr_q + 4'(off);
         if (!found_hi && mod_a[idx] == 2'b11) begin
            found_hi = 1'b1;
            win_hi   = idx;
         end
         if (!found_lo && mod_a[idx] != 2'b00) begin
            found_lo = 1'b1;
            win_lo   = idx;
         end
      end
      any_req = found_lo;
      win     = found_hi ? win_hi : win_lo;
   end

   assign sel_addr   = (mod_a[win] == 2'b10) ? 4'hF : addr_a[win];
   assign frame_tail = {win, sel_addr, mod_a[win], data_a[win], sel_crc};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = SEND;
         SEND:    if (bit_cnt_q == 7'd78) state_d = GAP;
         GAP:     if (gap_cnt_q == 4'(GAP_CYCLES - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Control and line driver; the grant edge drives the start bit directly
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q     <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         bus_out   <= 1'b0;
`ifdef CRC_GEN_EN
         crc_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  ptr_q     <= win + 4'd1;
                  bit_cnt_q <= 7'd1;
                  bus_out   <= 1'b1;
`ifdef CRC_GEN_EN
                  crc_q     <= '0;
`endif
               end else begin
                  bus_out   <= 1'b0;
               end
            end
            SEND: begin
               bit_cnt_q <= bit_cnt_q + 7'd1;
`ifdef CRC_GEN_EN
               if (bit_cnt_q >= 7'd75) begin
                  bus_out <= crc_q[3];
                  crc_q   <= {crc_q[2:0], 1'b0};
               end else begin
                  bus_out <= shift_q[SHIFT_W-1];
                  crc_q   <= crc4_step(crc_q, shift_q[SHIFT_W-1]);
               end
`else
               bus_out   <= shift_q[SHIFT_W-1];
`endif
               if (bit_cnt_q == 7'd78) gap_cnt_q <= '0;
            end
            GAP: begin
               bus_out   <= 1'b0;
               gap_cnt_q <= gap_cnt_q + 4'd1;
            end
            default: bus_out <= 1'b0;
         endcase
      end
   end

   // Frame shift register: loaded while idle, so the grant edge captures the winner's fields
   always_ff @(posedge clock) begin
      if (state_q == IDLE)      shift_q <= frame_tail;
      else if (state_q == SEND) shift_q <= {shift_q[SHIFT_W-2:0], 1'b0};
   end

endmodule

// File: tb/tb_fpga.sv
// Randomized self-checking bench for fpga: a frame-level reference model predicts every bus_out cycle.
module tb_fpga;

   localparam int G = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  mod_s  [16];
   logic [3:0]  addr_s [16];
   logic [3:0]  crc_s  [16];
   logic [63:0] data_s [16];
   logic        bus_out;

   int   checks = 0;
   int   errors = 0;
   int   p_m = 1;
   int   grants = 0;
   bit   exp_q [$];
   bit   fb_m [79];
   logic exp_bus = 1'b0;

   always #5 clock = ~clock;

   fpga #(.GAP_CYCLES(G)) dut (
      .clock(clock), .reset(reset),
      .CRC1(crc_s[0]),   .Data1(data_s[0]),   .receiverAddr1(addr_s[0]),   .mod1(mod_s[0]),
      .CRC2(crc_s[1]),   .Data2(data_s[1]),   .receiverAddr2(addr_s[1]),   .mod2(mod_s[1]),
      .CRC3(crc_s[2]),   .Data3(data_s[2]),   .receiverAddr3(addr_s[2]),   .mod3(mod_s[2]),
      .CRC4(crc_s[3]),   .Data4(data_s[3]),   .receiverAddr4(addr_s[3]),   .mod4(mod_s[3]),
      .CRC5(crc_s[4]),   .Data5(data_s[4]),   .receiverAddr5(addr_s[4]),   .mod5(mod_s[4]),
      .CRC6(crc_s[5]),   .Data6(data_s[5]),   .receiverAddr6(addr_s[5]),   .mod6(mod_s[5]),
      .CRC7(crc_s[6]),   .Data7(data_s[6]),   .receiverAddr7(addr_s[6]),   .mod7(mod_s[6]),
      .CRC8(crc_s[7]),   .Data8(data_s[7]),   .receiverAddr8(addr_s[7]),   .mod8(mod_s[7]),
      .CRC9(crc_s[8]),   .Data9(data_s[8]),   .receiverAddr9(addr_s[8]),   .mod9(mod_s[8]),
      .CRC10(crc_s[9]),  .Data10(data_s[9]),  .receiverAddr10(addr_s[9]),  .mod10(mod_s[9]),
      .CRC11(crc_s[10]), .Data11(data_s[10]), .receiverAddr11(addr_s[10]), .mod11(mod_s[10]),
      .CRC12(crc_s[11]), .Data12(data_s[11]), .receiverAddr12(addr_s[11]), .mod12(mod_s[11]),
      .CRC13(crc_s[12]), .Data13(data_s[12]), .receiverAddr13(addr_s[12]), .mod13(mod_s[12]),
      .CRC14(crc_s[13]), .Data14(data_s[13]), .receiverAddr14(addr_s[13]), .mod14(mod_s[13]),
      .CRC15(crc_s[14]), .Data15(data_s[14]), .receiverAddr15(addr_s[14]), .mod15(mod_s[14]),
      .CRC16(crc_s[15]), .Data16(data_s[15]), .receiverAddr16(addr_s[15]), .mod16(mod_s[15]),
      .bus_out(bus_out)
   );

   // CRC-4 as the remainder of polynomial long division of (bits 1..74)*x^4 by x^4+x+1
   function automatic logic [3:0] ref_crc();
      bit r [79];
      for (int i = 0; i < 79; i++) r[i] = (i >= 1 && i <= 74) ? fb_m[i] : 1'b0;
      for (int i = 1; i <= 74; i++) begin
         if (r[i]) begin
            r[i]   = ~r[i];
            r[i+3] = ~r[i+3];
            r[i+4] = ~r[i+4];
         end
      end
      return {r[75], r[76], r[77], r[78]};
   endfunction

   task automatic model_grant();
      int         win;
      logic [3:0] sid, a, c;
      logic [1:0] m;
      win = -1;
      for (int off = 0; off < 16; off++) begin
         int s;
         s = (p_m - 1 + off) % 16;
         if (win < 0 && mod_s[s] == 2'b11) win = s;
      end
      for (int off = 0; off < 16; off++) begin
         int s;
         s = (p_m - 1 + off) % 16;
         if (win < 0 && mod_s[s] != 2'b00) win = s;
      end
      if (win < 0) return;
      sid = 4'(win);
      m   = mod_s[win];
      a   = (m == 2'b10) ? 4'hF : addr_s[win];
      fb_m[0] = 1'b1;
      for (int i = 0; i < 4; i++) fb_m[1+i] = sid[3-i];
      for (int i = 0; i < 4; i++) fb_m[5+i] = a[3-i];
      fb_m[9]  = m[1];
      fb_m[10] = m[0];
      for (int i = 0; i < 64; i++) fb_m[11+i] = data_s[win][63-i];
`ifdef CRC_GEN_EN
      c = ref_crc();
`else
      c = crc_s[win];
`endif
      for (int i = 0; i < 4; i++) fb_m[75+i] = c[3-i];
      for (int i = 0; i < 79; i++) exp_q.push_back(fb_m[i]);
      repeat (G) exp_q.push_back(1'b0);
      p_m = (win + 1) % 16 + 1;
      grants++;
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         exp_q.delete();
         p_m     = 1;
         exp_bus = 1'b0;
      end else begin
         if (exp_q.size() == 0) model_grant();
         if (exp_q.size() != 0) exp_bus = exp_q.pop_front();
         else                   exp_bus = 1'b0;
      end
      #1;
   endtask

   task automatic clear_inputs();
      for (int s = 0; s < 16; s++) begin
         mod_s[s]  = 2'b00;
         addr_s[s] = 4'h0;
         crc_s[s]  = 4'h0;
         data_s[s] = 64'h0;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: bus_out=%b expected 0", bus_out);
      end
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         tick();
         checks++;
         if (bus_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet cycle %0d: bus_out=%b expected 0", c, bus_out);
         end
      end
   endtask

   task automatic test_single();
      logic [10:0] hdr;
      logic [63:0] dat;
      logic [3:0]  crcf;
      hdr = '0; dat = '0; crcf = '0;
      clear_inputs();
      pulse_reset();
      mod_s[0]  = 2'b01;
      addr_s[0] = 4'd3;
      data_s[0] = 64'hA5A5_0000_FFFF_1234;
      crc_s[0]  = 4'h5;
      tick();
      mod_s[0]  = 2'b00;
      data_s[0] = ~data_s[0];
      addr_s[0] = 4'hC;
      crc_s[0]  = 4'hA;
      for (int i = 0; i < 90; i++) begin
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL single_bit %0d: bus_out=%b expected %b", i, bus_out, exp_bus);
         end
         if (i < 11) hdr = {hdr[9:0], bus_out};
         else if (i < 75) dat = {dat[62:0], bus_out};
         else if (i < 79) crcf = {crcf[2:0], bus_out};
         tick();
      end
      checks++;
      if (hdr !== 11'b1_0000_0011_01) begin
         errors++;
         $display("FAIL single_header: got %b expected 10000001101", hdr);
      end
      checks++;
      if (dat !== 64'hA5A5_0000_FFFF_1234) begin
         errors++;
         $display("FAIL single_data: got %h expected a5a50000ffff1234", dat);
      end
`ifndef CRC_GEN_EN
      checks++;
      if (crcf !== 4'h5) begin
         errors++;
         $display("FAIL single_crc: got %b expected 0101", crcf);
      end
`endif
   endtask

   task automatic test_contention();
      logic [3:0] sender;
      sender = '0;
      clear_inputs();
      mod_s[0]   = 2'b01;
      mod_s[15]  = 2'b01;
      data_s[0]  = {$urandom, $urandom};
      data_s[15] = {$urandom, $urandom};
      addr_s[0]  = 4'($urandom);
      addr_s[15] = 4'($urandom);
      crc_s[0]   = 4'($urandom);
      crc_s[15]  = 4'($urandom);
      pulse_reset();
      tick();
      for (int c = 0; c < 3 * 81 + 4; c++) begin
         int f, off;
         f   = c / 81;
         off = c % 81;
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL contention_bit cycle %0d: bus_out=%b expected %b", c, bus_out, exp_bus);
         end
         if (f < 3 && off == 0) begin
            checks++;
            if (bus_out !== 1'b1) begin
               errors++;
               $display("FAIL contention_start frame %0d: bus_out=%b expected 1", f, bus_out);
            end
         end
         if (off >= 1 && off <= 4) sender = {sender[2:0], bus_out};
         if (f < 3 && off == 4) begin
            checks++;
            if (sender !== ((f == 1) ? 4'hF : 4'h0)) begin
               errors++;
               $display("FAIL contention_sender frame %0d: got %h expected %h", f, sender,
                        (f == 1) ? 4'hF : 4'h0);
            end
         end
         tick();
      end
   endtask

   task automatic test_priority();
      logic [3:0] sender;
      sender = '0;
      clear_inputs();
      pulse_reset();
      mod_s[1]  = 2'b01;
      mod_s[8]  = 2'b11;
      data_s[1] = {$urandom, $urandom};
      data_s[8] = {$urandom, $urandom};
      addr_s[1] = 4'($urandom);
      addr_s[8] = 4'($urandom);
      crc_s[1]  = 4'($urandom);
      crc_s[8]  = 4'($urandom);
      tick();
      mod_s[8] = 2'b00;
      for (int c = 0; c < 2 * 81 + 4; c++) begin
         int f, off;
         f   = c / 81;
         off = c % 81;
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL priority_bit cycle %0d: bus_out=%b expected %b", c, bus_out, exp_bus);
         end
         if (off >= 1 && off <= 4) sender = {sender[2:0], bus_out};
         if (f < 2 && off == 4) begin
            checks++;
            if (sender !== ((f == 0) ? 4'd8 : 4'd1)) begin
               errors++;
               $display("FAIL priority_sender frame %0d: got %0d expected %0d", f, sender,
                        (f == 0) ? 8 : 1);
            end
         end
         tick();
      end
   endtask

   task automatic test_broadcast();
      logic [5:0] fld;
      fld = '0;
      clear_inputs();
      pulse_reset();
      mod_s[3]  = 2'b10;
      addr_s[3] = 4'd2;
      data_s[3] = {$urandom, $urandom};
      crc_s[3]  = 4'($urandom);
      tick();
      mod_s[3] = 2'b00;
      for (int i = 0; i < 85; i++) begin
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL broadcast_bit %0d: bus_out=%b expected %b", i, bus_out, exp_bus);
         end
         if (i >= 5 && i <= 10) fld = {fld[4:0], bus_out};
         tick();
      end
      checks++;
      if (fld !== 6'b1111_10) begin
         errors++;
         $display("FAIL broadcast_fields: got %b expected 111110", fld);
      end
   endtask

   task automatic test_reset_mid();
      bit         hit;
      int         base;
      logic [3:0] sender;
      hit = 1'b0;
      sender = '0;
      clear_inputs();
      mod_s[0]  = 2'b01;
      mod_s[5]  = 2'b01;
      mod_s[10] = 2'b10;
      for (int s = 0; s < 16; s++) begin
         data_s[s] = {$urandom, $urandom};
         addr_s[s] = 4'($urandom);
         crc_s[s]  = 4'($urandom);
      end
      pulse_reset();
      base = grants;
      for (int c = 0; c < 400 && !hit; c++) begin
         tick();
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL midreset_bit cycle %0d: bus_out=%b expected %b", c, bus_out, exp_bus);
         end
         if (grants - base == 2 && exp_q.size() == 38 + G) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL midreset_timeout: bit 40 of second frame not reached, got %0d grants expected 2",
                  grants - base);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus_out !== 1'b0) begin
         errors++;
         $display("FAIL midreset_out: bus_out=%b expected 0", bus_out);
      end
      tick();
      checks++;
      if (bus_out !== 1'b1) begin
         errors++;
         $display("FAIL midreset_restart: bus_out=%b expected 1", bus_out);
      end
      for (int i = 1; i < 100; i++) begin
         tick();
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL midreset_after bit %0d: bus_out=%b expected %b", i, bus_out, exp_bus);
         end
         if (i <= 4) sender = {sender[2:0], bus_out};
      end
      checks++;
      if (sender !== 4'h0) begin
         errors++;
         $display("FAIL midreset_sender: got %h expected 0", sender);
      end
   endtask

   task automatic test_random();
      clear_inputs();
      pulse_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int s = 0; s < 16; s++) begin
            if ($urandom_range(0, 7) == 0) begin
               int r;
               r = $urandom_range(0, 9);
               mod_s[s]  = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
               addr_s[s] = 4'($urandom);
               crc_s[s]  = 4'($urandom);
               data_s[s] = {$urandom, $urandom};
            end
         end
         reset = ($urandom_range(0, 399) == 0);
         tick();
         checks++;
         if (bus_out !== exp_bus) begin
            errors++;
            $display("FAIL random_bit cycle %0d: bus_out=%b expected %b", c, bus_out, exp_bus);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_priority();
      test_broadcast();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

endmodule
